conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl_if.sv | 48 ++++
 rtl/conv_window_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if -- pixel-stream and window handshake bundle for conv_window_ctrl.
//
// Signals
//   in_valid / in_data / in_ready : upstream pixel stream (valid/ready)
//   shift_en / shift_data         : advance pulse and pixel for the delay/line-buffer chain
//   win_valid / win_ready         : complete KxK window offered to / consumed by the MAC array
//   win_row / win_col             : top-left coordinate of the offered window
//
// Modports
//   slave  : the controller side (conv_window_ctrl)
//   master : the surrounding environment (pixel source, delay chain, MAC array)
interface conv_window_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              shift_en;
    logic [DATA_W-1:0] shift_data;
    logic              win_valid;
    logic              win_ready;
    logic [9:0]        win_row;
    logic [9:0]        win_col;

    modport slave (
        input  in_valid,
        input  in_data,
        input  win_ready,
        output in_ready,
        output shift_en,
        output shift_data,
        output win_valid,
        output win_row,
        output win_col
    );

    modport master (
        output in_valid,
        output in_data,
        output win_ready,
        input  in_ready,
        input  shift_en,
        input  shift_data,
        input  win_valid,
        input  win_row,
        input  win_col
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl -- sliding-window controller for a KxK convolution over an
// IMG_W x IMG_H feature map streamed in row-major order.
//
// Pixels are accepted while a frame is running and the previous window is either
// absent or being consumed. Every accepted pixel pulses shift_en so the external
// delay chain advances; once a pixel at (r,c) with r,c >= K-1 has been shifted in,
// the chain holds a full window whose top-left corner is (r-K+1, c-K+1).
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle frame start, only honoured when idle
//   bus          : conv_window_ctrl_if.slave (pixel stream, shift, window handshake)
//   busy         : a frame is in progress (running or holding its last window)
//   done         : one-cycle pulse on the handshake of the frame's last window
//   stall_cnt    : (only with CONV_WINDOW_CTRL_STALL_CNT_EN) saturating count of
//                  cycles with a window offered but not consumed
//
// Optional feature macro: CONV_WINDOW_CTRL_STALL_CNT_EN
module conv_window_ctrl #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    conv_window_ctrl_if.slave bus,
    output logic              busy,
    output logic              done
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
    localparam logic [9:0] K_M1     = 10'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [9:0]        row_r;
    logic [9:0]        col_r;
    logic [9:0]        win_row_r;
    logic [9:0]        win_col_r;
    logic              win_valid_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              consume_s;
    logic              last_pix_s;
    logic              win_pix_s;
    logic              done_s;
    logic              start_ok_s;
    logic [DATA_W-1:0] pix_s;

    // Handshake decode: acceptance, window consumption and pixel classification.
    always_comb begin
        in_ready_s = 1'b0;
        // A new pixel may only enter when it cannot overwrite an unconsumed window.
        if (!reset && (state_r == ST_RUN)) begin
            in_ready_s = !win_valid_r || bus.win_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s   = in_ready_s && bus.in_valid;
        consume_s  = win_valid_r && bus.win_ready;
        last_pix_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
        win_pix_s  = (row_r >= K_M1) && (col_r >= K_M1);
        done_s     = !reset && (state_r == ST_HOLD) && consume_s;
        start_ok_s = (state_r == ST_IDLE) && start;
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_pix_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                // The last pixel always completes a window, so HOLD just waits for it to drain.
                if (consume_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Row/column position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= 10'd0;
            col_r <= 10'd0;
        end else if (start_ok_s) begin
            row_r <= 10'd0;
            col_r <= 10'd0;
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= 10'd0;
                if (row_r == ROW_LAST) begin
                    row_r <= 10'd0;
                end else begin
                    row_r <= row_r + 10'd1;
                end
            end else begin
                col_r <= col_r + 10'd1;
            end
        end
    end

    // Window-valid flag and its top-left coordinate; a window-completing accept in
    // the same cycle as a consume replaces the old window without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_r <= 1'b0;
            win_row_r   <= 10'd0;
            win_col_r   <= 10'd0;
        end else if (accept_s && win_pix_s) begin
            win_valid_r <= 1'b1;
            win_row_r   <= row_r - K_M1;
            win_col_r   <= col_r - K_M1;
        end else if (accept_s || consume_s) begin
            win_valid_r <= 1'b0;
        end
    end

`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of back-pressured window cycles for the current frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'd0;
        end else if (start_ok_s) begin
            stall_cnt_r <= 16'd0;
        end else if (win_valid_r && !bus.win_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign pix_s          = bus.in_data;
    assign bus.shift_data = pix_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.shift_en   = accept_s;
    assign bus.win_valid  = win_valid_r;
    assign bus.win_row    = win_row_r;
    assign bus.win_col    = win_col_r;
    assign busy           = (state_r != ST_IDLE);
    assign done           = done_s;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl -- self-checking bench for conv_window_ctrl.
// Main instance: 8x8 map, K=3. Second instance: 4x4 map, K=4 (single window).
module tb_conv_window_ctrl;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int KK   = 3;
    localparam int NPIX = IW * IH;
    localparam int WW   = IW - KK + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    conv_window_ctrl_if #(.DATA_W(8)) b ();
    conv_window_ctrl_if #(.DATA_W(8)) b2 ();

    conv_window_ctrl #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH), .K(KK)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(b), .busy(busy), .done(done)
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    conv_window_ctrl #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .K(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(b2), .busy(busy2), .done(done2)
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: frame activity, accepted pixel count, pending window.
    logic m_active = 1'b0;
    logic m_wv = 1'b0;
    int   m_n = 0;
    int   m_wr = 0;
    int   m_wc = 0;
    int   m_stall = 0;
    logic chk_en = 1'b0;
    int   cyc = 0;
    int   cnt_shift = 0;
    int   cnt_win = 0;
    int   cnt_done = 0;
    int   acc18_cyc = -1;
    int   first_wv_cyc = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin : compare
        logic e_rdy, e_acc, e_cons, e_done;
        int   r, c;
        cyc++;
        e_rdy  = m_active && (m_n < NPIX) && (!m_wv || b.win_ready);
        e_acc  = e_rdy && b.in_valid;
        e_cons = m_wv && b.win_ready;
        e_done = m_active && (m_n == NPIX) && e_cons;
        if (chk_en) begin
            chk("win_valid", 32'(b.win_valid), 32'(m_wv));
            chk("busy", 32'(busy), 32'(m_active));
            if (m_wv) begin
                chk("win_row", 32'(b.win_row), 32'(m_wr));
                chk("win_col", 32'(b.win_col), 32'(m_wc));
            end
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
            if (!reset) begin
                chk("in_ready", 32'(b.in_ready), 32'(e_rdy));
                chk("shift_en", 32'(b.shift_en), 32'(e_acc));
                chk("done", 32'(done), 32'(e_done));
                chk("shift_data", 32'(b.shift_data), 32'(b.in_data));
                if (b.shift_en) cnt_shift++;
                if (done) cnt_done++;
                if (b.shift_en && (m_n == 18) && (acc18_cyc < 0)) acc18_cyc = cyc;
                if (b.win_valid && (first_wv_cyc < 0)) first_wv_cyc = cyc;
                if (b.win_valid && b.win_ready) begin
                    chk("seq_row", 32'(b.win_row), 32'(cnt_win / WW));
                    chk("seq_col", 32'(b.win_col), 32'(cnt_win % WW));
                    cnt_win++;
                end
            end
        end
        if (reset) begin
            m_active = 1'b0; m_wv = 1'b0; m_n = 0; m_wr = 0; m_wc = 0; m_stall = 0;
        end else if (!m_active && start) begin
            m_active = 1'b1; m_n = 0; m_stall = 0;
        end else begin
            if (m_wv && !b.win_ready && (m_stall < 65535)) m_stall++;
            if (e_acc) begin
                r = m_n / IW;
                c = m_n % IW;
                m_n++;
                if ((r >= KK - 1) && (c >= KK - 1)) begin
                    m_wv = 1'b1; m_wr = r - (KK - 1); m_wc = c - (KK - 1);
                end else begin
                    m_wv = 1'b0;
                end
            end else if (e_cons) begin
                m_wv = 1'b0;
            end
            if (e_done) m_active = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        cnt_shift = 0; cnt_win = 0; cnt_done = 0; acc18_cyc = -1; first_wv_cyc = -1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_all_high(input string tag);
        b.in_valid = 1'b1;
        b.win_ready = 1'b1;
        begin_frame();
        for (int i = 0; i < 500 && cnt_done == 0; i++) begin
            b.in_data = 8'($urandom);
            step();
        end
        chk({tag, "_done"}, 32'(cnt_done), 32'd1);
        chk({tag, "_shifts"}, 32'(cnt_shift), 32'd64);
        chk({tag, "_wins"}, 32'(cnt_win), 32'd36);
    endtask

    initial begin : driver
        int left, stalled, hold_pulses, acc, early;
        b.in_valid = 1'b0; b.in_data = 8'd0; b.win_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = 8'd0; b2.win_ready = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_win_valid", 32'(b.win_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_win_row", 32'(b.win_row), 32'd0);
        chk("rst_win_col", 32'(b.win_col), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(b.in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Frame A: everything flowing, first-window latency pinned.
        run_all_high("A");
        chk("A_first_latency", 32'(first_wv_cyc - acc18_cyc), 32'd1);
        step();
        chk("A_idle_after", 32'(busy), 32'd0);

        // Frame B: five-cycle back-pressure on window (0,3).
        b.in_valid = 1'b1; b.win_ready = 1'b1;
        begin_frame();
        stalled = 0; left = 0;
        for (int i = 0; i < 500 && cnt_done == 0; i++) begin
            b.in_data = 8'($urandom);
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    b.win_ready = 1'b1;
                end else if (left == 2) begin
                    chk("B_hold_row", 32'(b.win_row), 32'd0);
                    chk("B_hold_col", 32'(b.win_col), 32'd3);
                    chk("B_hold_in_ready", 32'(b.in_ready), 32'd0);
                    chk("B_hold_shift_en", 32'(b.shift_en), 32'd0);
                end
            end else if ((stalled == 0) && b.win_valid && (b.win_row == 10'd0) && (b.win_col == 10'd3)) begin
                stalled = 1; left = 5; b.win_ready = 1'b0;
            end
            step();
        end
        chk("B_stall_seen", 32'(stalled), 32'd1);
        chk("B_done", 32'(cnt_done), 32'd1);
        chk("B_shifts", 32'(cnt_shift), 32'd64);
        chk("B_wins", 32'(cnt_win), 32'd36);
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        step();
        chk("B_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

        // Frame C: random gaps and back-pressure, stray starts in RUN and HOLD.
        begin_frame();
        hold_pulses = 0;
        for (int i = 0; i < 3000 && cnt_done == 0; i++) begin
            b.in_data = 8'($urandom);
            b.in_valid = 1'($urandom_range(0, 1));
            b.win_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            if ((m_n == NPIX) && (hold_pulses < 3)) begin
                start = 1'b1; b.win_ready = 1'b0; hold_pulses++;
            end
            step();
        end
        start = 1'b0;
        chk("C_hold_reached", 32'(hold_pulses), 32'd3);
        chk("C_done", 32'(cnt_done), 32'd1);
        chk("C_shifts", 32'(cnt_shift), 32'd64);
        chk("C_wins", 32'(cnt_win), 32'd36);
        step();
        chk("C_idle_after", 32'(busy), 32'd0);

        // Frame D: abandon with reset after 20 accepts, then a fresh full frame.
        begin_frame();
        for (int i = 0; i < 500 && m_n < 20; i++) begin
            b.in_data = 8'($urandom);
            b.in_valid = 1'($urandom_range(0, 1));
            b.win_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("D_pre_accepts", 32'(cnt_shift), 32'd20);
        reset = 1'b1; b.in_valid = 1'b0;
        step();
        chk("D_win_valid", 32'(b.win_valid), 32'd0);
        chk("D_busy", 32'(busy), 32'd0);
        chk("D_win_row", 32'(b.win_row), 32'd0);
        chk("D_win_col", 32'(b.win_col), 32'd0);
        reset = 1'b0;
        #1;
        chk("D_in_ready", 32'(b.in_ready), 32'd0);
        chk("D_shift_en", 32'(b.shift_en), 32'd0);
        chk("D_no_done", 32'(cnt_done), 32'd0);
        run_all_high("E");

        // Second instance: K equals the map size, one window after the 16th accept.
        b2.in_valid = 1'b1; b2.win_ready = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        acc = 0; early = 0;
        for (int i = 0; i < 60 && acc < 16; i++) begin
            @(negedge clk);
            if (b2.win_valid) early++;
            if (b2.shift_en) acc++;
            step();
        end
        @(negedge clk);
        chk("K4_accepts", 32'(acc), 32'd16);
        chk("K4_no_early_window", 32'(early), 32'd0);
        chk("K4_win_valid", 32'(b2.win_valid), 32'd1);
        chk("K4_win_row", 32'(b2.win_row), 32'd0);
        chk("K4_win_col", 32'(b2.win_col), 32'd0);
        chk("K4_done", 32'(done2), 32'd1);
        chk("K4_in_ready", 32'(b2.in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("K4_busy_after", 32'(busy2), 32'd0);
        chk("K4_win_valid_after", 32'(b2.win_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
